// File: rtl/mem_access_stage_if.sv
// Data-memory port between the memory-access stage (master) and the data memory (slave).
// The master drives request, write enable, word address, byte enables and lane-aligned data.
interface mem_access_stage_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [3:0]             mem_be;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic                   mem_ready;
    logic [DATA_LENGTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: aligns stores, extends loads, drives a variable-latency
// data-memory port and stalls the pipeline until the access completes.
//
// state | meaning
// IDLE  | no access in flight; decode and launch or fault a new access
// REQ   | request held on the memory port, waiting for mem_ready or watchdog
// DONE  | one unstalled cycle presenting read_data_out / fault_out to MEM/WB
module mem_access_stage #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [2:0]             funct3_in,
    input  logic [ADDR_WIDTH-1:0]  alu_res_in,
    input  logic [DATA_LENGTH-1:0] write_data_in,
    output logic [DATA_LENGTH-1:0] read_data_out,
    output logic                   stall_out,
    output logic                   fault_out,
    mem_access_stage_if.master     mem
);

    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]             mem_be_q, mem_be_d;
    logic [DATA_LENGTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             offset_q, offset_d;
    logic [DATA_LENGTH-1:0] read_data_q, read_data_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   acc;
    logic                   legal_f3;
    logic                   misaligned;
    logic                   bad;
    logic [1:0]             size;
    logic [1:0]             offset_in;
    logic [3:0]             be_new;
    logic [DATA_LENGTH-1:0] wdata_new;
    logic [DATA_LENGTH-1:0] rshift;
    logic [DATA_LENGTH-1:0] load_val;

    // Access decode: legality, alignment and store lane placement.
    always_comb begin
        acc       = valid_in & (mem_read_in | mem_write_in);
        size      = funct3_in[1:0];
        offset_in = alu_res_in[1:0];
        legal_f3  = 1'b0;
        if (mem_read_in) begin
            case (funct3_in)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                default:                                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3_in)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end
        misaligned = ((size == 2'b01) & offset_in[0]) |
                     ((size == 2'b10) & (offset_in != 2'b00));
        bad = (mem_read_in & mem_write_in) | ~legal_f3 | misaligned;

        case (size)
            2'b00:   be_new = 4'b0001 << offset_in;
            2'b01:   be_new = 4'b0011 << offset_in;
            default: be_new = 4'b1111;
        endcase
        case (size)
            2'b00:   wdata_new = {4{write_data_in[7:0]}};
            2'b01:   wdata_new = {2{write_data_in[15:0]}};
            default: wdata_new = write_data_in;
        endcase
    end

    always_comb begin
        rshift = mem.mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_val = {24'd0, rshift[7:0]};
            3'b101:  load_val = {16'd0, rshift[15:0]};
            default: load_val = rshift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        read_data_d = read_data_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        stall_out   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    stall_out = 1'b1;
                    if (bad) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write_in;
                        mem_addr_d  = {alu_res_in[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        funct3_d    = funct3_in;
                        offset_d    = offset_in;
                        fault_d     = 1'b0;
                        cnt_d       = '0;
                    end
                end
            end
            ST_REQ: begin
                stall_out = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    fault_d   = 1'b0;
                    if (!mem_we_q) begin
                        read_data_d = load_val;
                    end
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    fault_d   = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs still hold the finished op here; they are deliberately ignored.
                state_d = ST_IDLE;
                fault_d = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                fault_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            read_data_q <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign read_data_out = read_data_q;
    assign fault_out     = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a default-watchdog instance for normal traffic
// and a TIMEOUT_CYCLES=4 instance whose memory never answers.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, valid2_in, mem_read_in, mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_res_in, write_data_in;
    logic [31:0] read_data_out, read_data2;
    logic        stall_out, fault_out, stall2, fault2;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_WIDTH(32), .DATA_LENGTH(32)) bus ();
    mem_access_stage_if #(.ADDR_WIDTH(32), .DATA_LENGTH(32)) bus2 ();

    assign bus2.mem_ready = 1'b0;
    assign bus2.mem_rdata = 32'h5555_AAAA;

    mem_access_stage #(.DATA_LENGTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in), .alu_res_in(alu_res_in),
        .write_data_in(write_data_in), .read_data_out(read_data_out),
        .stall_out(stall_out), .fault_out(fault_out), .mem(bus)
    );

    mem_access_stage #(.DATA_LENGTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .valid_in(valid2_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in), .alu_res_in(alu_res_in),
        .write_data_in(write_data_in), .read_data_out(read_data2),
        .stall_out(stall2), .fault_out(fault2), .mem(bus2)
    );

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          stalls;
        int          reqs;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'h0;

    // Drives one access starting now (just after a falling edge) and checks it at DONE.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input logic bad,
                          input logic [3:0] be, input logic [31:0] wdata_exp,
                          input logic [31:0] rd_exp, input string name);
        exp_t e;
        exp_t got;
        int   st;
        int   rq;
        bit   done;
        e.rd     = (bad || wr) ? last_rd : rd_exp;
        e.fault  = bad;
        e.stalls = bad ? 1 : delay + 1;
        e.reqs   = bad ? 0 : delay;
        e.addr   = {addr[31:2], 2'b00};
        e.be     = be;
        e.we     = wr;
        e.wdata  = wdata_exp;
        last_rd  = e.rd;
        sb.push_back(e);
        st = 0;
        rq = 0;
        done = 0;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        alu_res_in = addr; write_data_in = wd; bus.mem_ready = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (bus.mem_req !== 1'b1) bus.mem_ready = 1'b0;
            if (stall_out === 1'b1) begin
                st++;
                if (bus.mem_req === 1'b1) begin
                    rq++;
                    tests++;
                    if ({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata} !==
                        {e.addr, e.be, e.we, e.wdata}) begin
                        fails++;
                        $display("FAIL %s req_fields cyc%0d: addr=%h be=%b we=%b wdata=%h, want addr=%h be=%b we=%b wdata=%h",
                                 name, rq, bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata,
                                 e.addr, e.be, e.we, e.wdata);
                    end
                    if (rq == delay) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = rdata;
                    end
                end
            end else if (st > 0) begin
                done = 1;
                got = sb.pop_front();
                tests++;
                if (read_data_out !== got.rd) begin
                    fails++;
                    $display("FAIL %s read_data: got %h want %h", name, read_data_out, got.rd);
                end
                tests++;
                if (fault_out !== got.fault) begin
                    fails++;
                    $display("FAIL %s fault: got %b want %b", name, fault_out, got.fault);
                end
                tests++;
                if (st != got.stalls || rq != got.reqs || bus.mem_req !== 1'b0) begin
                    fails++;
                    $display("FAIL %s timing: stalls=%0d reqs=%0d req_at_done=%b, want stalls=%0d reqs=%0d req_at_done=0",
                             name, st, rq, bus.mem_req, got.stalls, got.reqs);
                end
                valid_in = 1'b0;
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s done_timeout: no DONE after %0d stall cycles, want completion", name, st);
            void'(sb.pop_front());
            valid_in = 1'b0;
            bus.mem_ready = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        bus.mem_ready = 1'b0;
        tests++;
        if (bus.mem_req !== 1'b0 || stall_out !== 1'b0) begin
            fails++;
            $display("FAIL %s reissue: mem_req=%b stall=%b after DONE, want 0 0", name, bus.mem_req, stall_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_in = 1'b0; valid2_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = 3'b000; alu_res_in = 32'h0; write_data_in = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 70'h0) begin
            fails++;
            $display("FAIL reset_bus: req=%b we=%b be=%b addr=%h wdata=%h, want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if (read_data_out !== 32'h0 || fault_out !== 1'b0 || stall_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: rd=%h fault=%b stall=%b, want 0 0 0", read_data_out, fault_out, stall_out);
        end
        tests++;
        if (bus2.mem_req !== 1'b0 || read_data2 !== 32'h0 || fault2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_wdog_inst: req=%b rd=%h fault=%b, want 0", bus2.mem_req, read_data2, fault2);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_loads();
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h0, 32'hDEADBEEF, "lw_100");
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 4'b1000, 32'h0, 32'hFFFFFF80, "lb_103");
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 4'b1000, 32'h0, 32'h00000080, "lbu_103");
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, 0, 4'b1100, 32'h0, 32'h000080FF, "lhu_102");
        run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1, 0, 4'b1100, 32'h0, 32'hFFFF80FF, "lh_102");
        run_op(1, 0, 3'b000, 32'h100, 32'h0, 32'h80FF1234, 1, 0, 4'b0001, 32'h0, 32'h00000034, "lb_100");
        run_op(1, 0, 3'b001, 32'h100, 32'h0, 32'h80FF9234, 1, 0, 4'b0011, 32'h0, 32'hFFFF9234, "lh_100");
    endtask

    task automatic test_stores();
        run_op(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 1, 0, 4'b0010, 32'hABABABAB, 32'h0, "sb_201");
        run_op(0, 1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1, 0, 4'b1100, 32'h12341234, 32'h0, "sh_202");
        run_op(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0, "sw_204");
        run_op(0, 1, 3'b000, 32'h203, 32'h7777775A, 32'hFFFFFFFF, 2, 0, 4'b1000, 32'h5A5A5A5A, 32'h0, "sb_203");
    endtask

    task automatic test_delay();
        run_op(1, 0, 3'b010, 32'h180, 32'h0, 32'h12345678, 5, 0, 4'b1111, 32'h0, 32'h12345678, "lw_delay5");
        run_op(1, 0, 3'b100, 32'h181, 32'h0, 32'h0000CD00, 3, 0, 4'b0010, 32'h0, 32'h000000CD, "lbu_delay3");
    endtask

    task automatic test_bad();
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h0, "lw_misaligned");
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h0, "load_f3_011");
        run_op(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h0, "store_f3_100");
        run_op(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h0, "read_and_write");
        run_op(0, 1, 3'b001, 32'h203, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h0, "sh_misaligned");
    endtask

    task automatic test_back_to_back();
        run_op(0, 1, 3'b010, 32'h300, 32'h11223344, 32'h0, 1, 0, 4'b1111, 32'h11223344, 32'h0, "b2b_sw");
        run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h11223344, 1, 0, 4'b1111, 32'h0, 32'h11223344, "b2b_lw");
        run_op(1, 0, 3'b000, 32'h302, 32'h0, 32'h11F23344, 2, 0, 4'b0100, 32'h0, 32'hFFFFFFF2, "b2b_lb");
    endtask

    task automatic test_timeout();
        int  st;
        int  rq;
        bit  done;
        st = 0;
        rq = 0;
        done = 0;
        valid_in = 1'b0; valid2_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3_in = 3'b010; alu_res_in = 32'h340; write_data_in = 32'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (stall2 === 1'b1) begin
                st++;
                if (bus2.mem_req === 1'b1) rq++;
            end else if (st > 0) begin
                done = 1;
                tests++;
                if (rq != 4 || st != 5) begin
                    fails++;
                    $display("FAIL timeout_len: reqs=%0d stalls=%0d, want 4 5", rq, st);
                end
                tests++;
                if (fault2 !== 1'b1 || read_data2 !== 32'h0 || bus2.mem_req !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_done: fault=%b rd=%h req=%b, want 1 00000000 0", fault2, read_data2, bus2.mem_req);
                end
                valid2_in = 1'b0;
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout_wait: no DONE after %0d stalls, want DONE after 5", st);
            valid2_in = 1'b0;
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus2.mem_req !== 1'b0 || fault2 !== 1'b0) begin
            fails++;
            $display("FAIL timeout_after: req=%b fault=%b, want 0 0", bus2.mem_req, fault2);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h0, 32'hDEADBEEF, "pre_reset_lw");
        seen = 0;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        alu_res_in = 32'h140; bus.mem_ready = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_mid_req: mem_req=%b never rose, want 1", bus.mem_req);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || read_data_out !== 32'h0 || fault_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: req=%b rd=%h fault=%b, want 0 00000000 0", bus.mem_req, read_data_out, fault_out);
        end
        valid_in = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (stall_out !== 1'b0 || bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_idle: stall=%b req=%b, want 0 0", stall_out, bus.mem_req);
        end
        run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1, 0, 4'b1111, 32'h0, 32'h0BADF00D, "post_reset_lw");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_delay();
        test_bad();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the EX/MEM and MEM/WB pipeline registers of the RV32I core.
- Takes the ALU result as the address, plus store data and control, and drives a variable-latency data-memory port.
- Byte-aligns store data and byte enables; extracts and extends load data.
- Stalls the pipeline until the access completes; presents read_data_out to the MEM/WB data input.

Parameters:
DATA_LENGTH, 32, data width; only 32 is supported (4 byte lanes).
ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 255, maximum REQ cycles before abort; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
valid_in  in  1  EX/MEM holds a live instruction
mem_read_in  in  1  load
mem_write_in  in  1  store
funct3_in  in  3  access size/sign (RV32I encoding)
alu_res_in  in  ADDR_WIDTH  byte address
write_data_in  in  DATA_LENGTH  rs2 store data
read_data_out  out  DATA_LENGTH  extended load result, registered
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
fault_out  out  1  misaligned/illegal/timeout, valid in DONE only
mem_req  out  1  memory request, registered
mem_we  out  1  write enable
mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  DATA_LENGTH  lane-aligned store data
mem_ready  in  1  memory completes the access this cycle
mem_rdata  in  DATA_LENGTH  read word, valid with mem_ready

Behaviour:
- Reset (async, rst=0): state=IDLE; all registered outputs 0, including mem_req, mem_we, mem_be, mem_addr, mem_wdata, read_data_out and fault_out; watchdog counter=0.
- acc = valid_in & (mem_read_in | mem_write_in).
- bad = mem_read_in & mem_write_in, or an illegal funct3, or misalignment.
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store funct3: 000 SB, 001 SH, 010 SW. Any other code is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- IDLE:
  - No acc: stall_out=0.
  - acc & !bad: stall_out=1 (combinational). Latch we, addr, be, wdata, funct3 and offset=addr[1:0]; next state REQ.
  - acc & bad: stall_out=1; next state DONE with fault_out=1; no memory request.
- REQ:
  - mem_req=1; address, be, we and wdata held stable; stall_out=1; counter increments each cycle.
  - mem_ready=1: a load registers read_data_out; a store leaves read_data_out unchanged. Deassert mem_req; next state DONE; fault_out=0.
  - TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 without mem_ready: deassert mem_req; next state DONE with fault_out=1; read_data_out unchanged.
- DONE: stall_out=0 for exactly one cycle, so the pipeline advances and MEM/WB captures read_data_out. Inputs still show the finished op and must not re-issue. Next state IDLE; fault_out clears.
- Latency with mem_ready in the first REQ cycle: 2 stall cycles, result in the DONE cycle. Back-to-back accesses re-enter REQ from IDLE.
- Store lanes:
  - SB: byte replicated to all 4 lanes; be=0001<<offset.
  - SH: halfword replicated to both halves; be=0011<<offset.
  - SW: be=1111.
- Loads: r = mem_rdata >> (8*offset). LB/LH sign-extend r[7:0]/r[15:0]; LBU/LHU zero-extend; LW passes r unchanged.
- Memory side: mem_ready sampled only in REQ and ignored elsewhere.
- Reset mid-REQ: mem_req drops immediately (async). The access is abandoned; no completion is presented.

Test Plan:
- LW at 0x100, mem_ready in the 1st REQ cycle, mem_rdata=0xDEADBEEF → mem_addr=0x100, be=1111; stall high 2 cycles; DONE read_data_out=0xDEADBEEF, fault_out=0.
- LB at 0x103, rdata=0x80FF_1234 → read_data_out=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at 0x201, data=0x000000AB → mem_we=1, be=0010, wdata=0xABABABAB, mem_addr=0x200. SH at 0x202, data=0x1234 → be=1100, wdata=0x12341234.
- mem_ready delayed 5 cycles → mem_req and mem_addr stable all 5 cycles; stall high 6 cycles; single DONE; no re-issue.
- LW at 0x102, or funct3=011 → no mem_req; one stall cycle; DONE fault_out=1. TIMEOUT_CYCLES=4 with no ready → mem_req high 4 cycles, then fault_out=1.
- Assert rst=0 during REQ → mem_req=0 and read_data_out=0 in the same cycle; after release the block is in IDLE and a new LW completes normally.
